fetch_sequencer: RTL
====================

# fetch_sequencer

Owns the fetch program counter and sequences a variable-latency instruction memory with one outstanding request. Delivers fetched instructions into the IF/ID register and applies decode-stage stalls and EX/MEM branch redirects. Sits between the hazard/branch logic and the instruction memory, and replaces the free-running PC register in the fetch stage.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- stall  in  1  decode is not accepting; hold if_* outputs.
- redirect_valid  in  1  taken branch/jump from EX/MEM; one-cycle pulse or level.
- redirect_pc  in  32  redirect target; bits [1:0] ignored and forced to 0.
- imem_req  out  1  request strobe; combinational from state.
- imem_addr  out  32  request address; equals pc.
- imem_ack  in  1  response valid; at least 1 cycle after imem_req.
- imem_rdata  in  32  instruction word; valid when imem_ack=1.
- pc  out  32  current fetch PC, registered.
- if_valid  out  1  IF/ID holds a live instruction.
- if_instr  out  32  IF/ID instruction.
- if_pc  out  32  address of if_instr.

## Operation
- States: ISSUE, WAIT, HOLD, KILL. Reset enters ISSUE.
- Reset values: pc=RESET_PC, if_valid=0, if_instr=0, if_pc=0, skid register=0.
- imem_req = (state==ISSUE) & ~redirect_valid. imem_addr = pc at all times.
- Redirect has priority over stall and over imem_ack in every state. It sets pc<=redirect_pc & ~3 and if_valid<=0; if_instr and if_pc are don't-care.
- ISSUE: on redirect, stay in ISSUE with no request that cycle. Otherwise go to WAIT.
- WAIT, no ack: redirect -> KILL. Otherwise stay in WAIT. if_* hold if stall=1; if_valid<=0 if stall=0.
- WAIT, ack, redirect: drop the data and go to ISSUE.
- WAIT, ack, stall=0: if_instr<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+4, go to ISSUE.
- WAIT, ack, stall=1: skid<=imem_rdata, hold if_*, go to HOLD.
- HOLD: stall=1 holds everything.
- HOLD, stall=0: if_instr<=skid, if_pc<=pc, if_valid<=1, pc<=pc+4, go to ISSUE.
- HOLD, redirect: discard skid and go to ISSUE.
- KILL: waits for the stale ack and discards it, then goes to ISSUE. A redirect in KILL updates pc and stays in KILL.
- In ISSUE with no redirect: if_* hold if stall=1, else if_valid<=0 (bubble).
- pc+4 wraps modulo 2^32; 32'hFFFF_FFFC increments to 0.
- imem_ack in ISSUE or HOLD is a protocol error and is ignored. An assertion flags it.

## Timing
- Throughput with 1-cycle memory: one instruction per 2 cycles (ISSUE, WAIT).
- Latency: imem_req at cycle n, ack at n+k, if_valid high from n+k+1.
- Redirect at cycle r: pc=target at r+1. With no outstanding request, the first request for the target goes out at r+1. If a request is in flight, the target request goes out the cycle after the stale ack.
- Reset asserted mid-WAIT: outputs clear immediately (async). A stale ack arriving after reset deasserts is not protected; memory must be reset together with this block.
- stall and redirect_valid are sampled on the same edge. Redirect wins.

## Structure
- Shared package fetch_pkg: state enum fetch_state_t {ISSUE, WAIT, HOLD, KILL}; constants INSTR_BYTES=4 and PC_ALIGN_MASK=32'hFFFF_FFFC.
- One sub-module: fetch_skid_reg (32-bit load/hold register with async reset) for the HOLD buffer. All other logic is inline.

## Test plan
- Sequential fetch: reset, RESET_PC=0, ack 1 cycle after each req, no stall -> if_pc sequence 0,4,8,C; if_valid high every other cycle; if_instr matches the memory word.
- Stall on ack: stall=1 in the ack cycle for 3 cycles -> if_* unchanged for 3 cycles. After release, if_instr is the skid word with the correct if_pc, then the next req goes to pc+4.
- Redirect during WAIT: req to 0x10, redirect_pc=0x40 before ack, ack arrives 2 cycles later -> that ack is discarded, no if_valid for 0x10, next imem_addr=0x40.
- Redirect and ack in the same cycle with stall=1: redirect wins -> if_valid=0, pc=target, state ISSUE.
- Wrap and alignment: RESET_PC=0xFFFF_FFFC -> second fetch address is 0. redirect_pc=0x103 -> imem_addr=0x100.
- Async reset mid-HOLD: assert reset between edges -> pc=RESET_PC and if_valid=0 immediately; after release, imem_req is high in the first cycle.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch sequencer
package fetch_pkg;

   typedef enum logic [1:0] {ISSUE, WAIT, HOLD, KILL} fetch_state_t;

   localparam logic [31:0] INSTR_BYTES   = 32'd4;
   localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

   // Sequential successor; wraps modulo 2^32.
   function automatic logic [31:0] next_pc(input logic [31:0] pc);
      return pc + INSTR_BYTES;
   endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - instruction memory request/response bus
interface fetch_sequencer_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
   modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_skid_reg.sv
// rtl/fetch_skid_reg.sv - 32-bit load/hold register buffering a word caught during a stall
module fetch_skid_reg (
   input  logic        clk,
   input  logic        reset,
   input  logic        load_i,
   input  logic [31:0] d_i,
   output logic [31:0] q_o
);
   logic [31:0] data_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q <= '0;
      end else if (load_i) begin
         data_q <= d_i;
      end
   end

   assign q_o = data_q;
endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch PC owner driving a one-outstanding instruction memory into IF/ID
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     stall_i,
   input  logic                     redirect_valid_i,
   input  logic [31:0]              redirect_pc_i,
   fetch_sequencer_if.master        imem,
   output logic [31:0]              pc_o,
   output logic                     if_valid_o,
   output logic [31:0]              if_instr_o,
   output logic [31:0]              if_pc_o
);
   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic         if_valid_q, if_valid_d;
   logic [31:0]  if_instr_q, if_instr_d;
   logic [31:0]  if_pc_q, if_pc_d;
   logic         skid_load;
   logic [31:0]  skid_q;

   fetch_skid_reg u_skid (
      .clk    (clk),
      .reset  (reset),
      .load_i (skid_load),
      .d_i    (imem.imem_rdata),
      .q_o    (skid_q)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ISSUE;
         pc_q       <= RESET_PC;
         if_valid_q <= 1'b0;
         if_instr_q <= '0;
         if_pc_q    <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         if_valid_q <= if_valid_d;
         if_instr_q <= if_instr_d;
         if_pc_q    <= if_pc_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      if_valid_d = if_valid_q;
      if_instr_d = if_instr_q;
      if_pc_d    = if_pc_q;
      skid_load  = 1'b0;

      if (redirect_valid_i) begin
         // Redirect beats stall and ack; an in-flight request must still drain in KILL.
         pc_d       = redirect_pc_i & PC_ALIGN_MASK;
         if_valid_d = 1'b0;
         case (state_q)
            WAIT:    state_d = imem.imem_ack ? ISSUE : KILL;
            KILL:    state_d = imem.imem_ack ? ISSUE : KILL;
            default: state_d = ISSUE;
         endcase
      end else begin
         case (state_q)
            ISSUE: begin
               state_d = WAIT;
               if (!stall_i) if_valid_d = 1'b0;
            end
            WAIT: begin
               if (imem.imem_ack) begin
                  if (stall_i) begin
                     skid_load = 1'b1;
                     state_d   = HOLD;
                  end else begin
                     if_instr_d = imem.imem_rdata;
                     if_pc_d    = pc_q;
                     if_valid_d = 1'b1;
                     pc_d       = next_pc(pc_q);
                     state_d    = ISSUE;
                  end
               end else if (!stall_i) begin
                  if_valid_d = 1'b0;
               end
            end
            HOLD: begin
               if (!stall_i) begin
                  if_instr_d = skid_q;
                  if_pc_d    = pc_q;
                  if_valid_d = 1'b1;
                  pc_d       = next_pc(pc_q);
                  state_d    = ISSUE;
               end
            end
            KILL: begin
               if (imem.imem_ack) state_d = ISSUE;
               if (!stall_i) if_valid_d = 1'b0;
            end
            default: state_d = ISSUE;
         endcase
      end
   end

   assign imem.imem_req  = (state_q == ISSUE) & ~redirect_valid_i;
   assign imem.imem_addr = pc_q;
   assign pc_o           = pc_q;
   assign if_valid_o     = if_valid_q;
   assign if_instr_o     = if_instr_q;
   assign if_pc_o        = if_pc_q;

   // A response with nothing outstanding is a memory protocol violation.
   ack_only_when_outstanding: assert property (@(posedge clk) disable iff (reset)
      !(imem.imem_ack && (state_q == ISSUE || state_q == HOLD)));

endmodule
